// File: rtl/config_arbiter.sv
// Round-robin arbiter merging NUM_SRC configuration-flit sources into one registered output.
// Optional per-source accept counters are enabled with `define CONFIG_ARB_STATS_EN.

package config_arbiter_pkg;
    typedef struct packed {
        logic [7:0]  config_id;
        logic [31:0] payload;
    } config_flit_t;

    localparam logic [7:0] RATE_LIMIT_CONFIG_ID = 8'h2A;
endpackage

module config_arbiter
    import config_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
`ifdef CONFIG_ARB_STATS_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  config_flit_t [NUM_SRC-1:0]      in_config_data,
    input  logic [NUM_SRC-1:0]              in_config_valid,
    output logic [NUM_SRC-1:0]              in_config_ready,
    output config_flit_t                    out_config_data,
    output logic                            out_config_valid,
    input  logic                            out_config_ready,
    output logic [SRC_W-1:0]                out_src_id
`ifdef CONFIG_ARB_STATS_EN
    ,
    input  logic                            stats_clear,
    output logic [NUM_SRC-1:0][CNT_W-1:0]   stats_cnt
`endif
);

    config_flit_t     data_q, data_d;
    logic             valid_q, valid_d;
    logic [SRC_W-1:0] id_q, id_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             gnt_vld;
    logic [SRC_W-1:0] gnt_idx;
    logic             accept;

    // Circular search from rr_ptr: walking offsets high-to-low lets the
    // smallest offset with a valid request win.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] idx_w;
        idx     = 0;
        idx_w   = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx   = (int'(rr_ptr_q) + k) % NUM_SRC;
            idx_w = SRC_W'(idx);
            if (in_config_valid[idx_w]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_w;
            end
        end
    end

    always_comb begin
        load            = !valid_q || out_config_ready;
        accept          = rst && load && gnt_vld;
        in_config_ready = '0;
        if (accept) in_config_ready[gnt_idx] = 1'b1;

        data_d   = data_q;
        valid_d  = valid_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            valid_d = gnt_vld;
            if (gnt_vld) begin
                data_d   = in_config_data[gnt_idx];
                id_d     = gnt_idx;
                rr_ptr_d = SRC_W'((int'(gnt_idx) + 1) % NUM_SRC);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_config_data  = data_q;
    assign out_config_valid = valid_q;
    assign out_src_id       = id_q;

`ifdef CONFIG_ARB_STATS_EN
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a same-cycle accept; counters stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (stats_clear) begin
                cnt_d[i] = '0;
            end else if (accept && gnt_idx == SRC_W'(i) && cnt_q[i] != {CNT_W{1'b1}}) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign stats_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_config_arbiter.sv
// Randomized and directed bench for config_arbiter (NUM_SRC=3) against a transaction-level model.
// Build with CONFIG_ARB_STATS_EN to also exercise the saturating counters (CNT_W=4).

module tb_config_arbiter;
    import config_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int SW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    config_flit_t [N-1:0] in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    config_flit_t         out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SW-1:0]        out_src_id;
`ifdef CONFIG_ARB_STATS_EN
    logic                 stats_clear;
    logic [N-1:0][3:0]    stats_cnt;
    int                   m_cnt [N];
`endif

    always #5 clk = ~clk;

    config_arbiter #(
        .NUM_SRC(N)
`ifdef CONFIG_ARB_STATS_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_config_data   (in_data),
        .in_config_valid  (in_valid),
        .in_config_ready  (in_ready),
        .out_config_data  (out_data),
        .out_config_valid (out_valid),
        .out_config_ready (out_ready),
        .out_src_id       (out_src_id)
`ifdef CONFIG_ARB_STATS_EN
        , .stats_clear    (stats_clear)
        , .stats_cnt      (stats_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: round-robin pointer, output slot, delivered-flit count.
    int           m_ptr;
    bit           m_ov;
    config_flit_t m_od;
    int           m_oid;
    int           delivered = 0;
    bit           refill;
    bit           rnd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic config_flit_t rand_flit();
        config_flit_t f;
        f.config_id = 8'($urandom);
        f.payload   = $urandom;
        return f;
    endfunction

    function automatic int model_grant();
        if (!rst) return -1;
        if (m_ov && !out_ready) return -1;
        for (int k = 0; k < N; k++)
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // One clock: check against the model, advance the model on the edge,
    // then update sources on the falling edge.
    task automatic tick();
        int           g;
        logic [N-1:0] er;
        #1;
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data", 64'(out_data), 64'(m_od));
        chk("out_src_id", 64'(out_src_id), 64'(m_oid));
`ifdef CONFIG_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("stats_cnt", 64'(stats_cnt[i]), 64'(m_cnt[i]));
`endif
        @(posedge clk);
        if (rst && m_ov && out_ready) delivered++;
        if (!rst) begin
            m_ptr = 0; m_ov = 0; m_od = '0; m_oid = 0;
        end else if (!m_ov || out_ready) begin
            if (g >= 0) begin
                m_ov = 1; m_od = in_data[g]; m_oid = g; m_ptr = (g + 1) % N;
            end else begin
                m_ov = 0;
            end
        end
`ifdef CONFIG_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            if (!rst || stats_clear) m_cnt[i] = 0;
            else if (g == i && m_cnt[i] < 15) m_cnt[i]++;
        end
`endif
        @(negedge clk);
        if (g >= 0) begin
            if (refill) in_data[g] = rand_flit();
            else        in_valid[g] = 1'b0;
        end
        if (rnd) begin
            for (int i = 0; i < N; i++)
                if (!in_valid[i] && $urandom_range(1) == 1) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = rand_flit();
                end
            out_ready = ($urandom_range(3) != 0);
        end
    endtask

    initial begin
        config_flit_t bp;
        int           d0;
        rst       = 1'b0;
        out_ready = 1'b1;
        refill    = 1'b1;
        rnd       = 1'b0;
        in_valid  = '1;
        for (int i = 0; i < N; i++) in_data[i] = rand_flit();
        m_ptr = 0; m_ov = 0; m_od = '0; m_oid = 0;
`ifdef CONFIG_ARB_STATS_EN
        stats_clear = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
        @(negedge clk);

        // Reset held with every source requesting.
        repeat (3) begin
            tick();
            chk("rst_ready", 64'(in_ready), 64'd0);
        end
        rst = 1'b1;

        // Fairness: expected ids 0,1,2,0,1,2 back to back.
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fair_id", 64'(out_src_id), 64'(k % N));
            chk("fair_valid", 64'(out_valid), 64'd1);
        end

        refill = 1'b0;
        repeat (4) tick();
        chk("drained", 64'(out_valid), 64'd0);

        // Backpressure on a rate-limit flit from source 1.
        bp = rand_flit();
        bp.config_id = RATE_LIMIT_CONFIG_ID;
        in_data[1]  = bp;
        in_valid[1] = 1'b1;
        tick();
        chk("bp_data", 64'(out_data), 64'(bp));
        out_ready   = 1'b0;
        in_valid[0] = 1'b1;
        in_data[0]  = rand_flit();
        d0 = delivered;
        repeat (5) begin
            tick();
            chk("bp_hold_data", 64'(out_data), 64'(bp));
            chk("bp_hold_id", 64'(out_src_id), 64'd1);
            chk("bp_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_delivered_once", 64'(delivered), 64'(d0 + 1));
        repeat (2) tick();

        // Sparse: only source 1 requests.
        refill   = 1'b1;
        in_valid = 3'b010;
        repeat (4) begin
            tick();
            chk("sparse_id", 64'(out_src_id), 64'd1);
            chk("sparse_ptr", 64'(dut.rr_ptr_q), 64'd2);
        end
        refill = 1'b0;
        tick();

        // Reset while a flit is stalled in the output register.
        in_valid[0] = 1'b1;
        in_data[0]  = rand_flit();
        tick();
        out_ready = 1'b0;
        tick();
        chk("mid_valid_before", 64'(out_valid), 64'd1);
        rst = 1'b0;
        tick();
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_data", 64'(out_data), 64'd0);
        chk("mid_id", 64'(out_src_id), 64'd0);
        chk("mid_ptr", 64'(dut.rr_ptr_q), 64'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;

        // Random traffic with random backpressure.
        rnd = 1'b1;
        repeat (400) tick();
        rnd = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();

`ifdef CONFIG_ARB_STATS_EN
        rst = 1'b0;
        tick();
        rst      = 1'b1;
        refill   = 1'b1;
        in_valid = 3'b001;
        in_data[0] = rand_flit();
        repeat (20) tick();
        chk("stats_sat", 64'(stats_cnt[0]), 64'd15);
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        chk("stats_clear", 64'(stats_cnt[0]), 64'd0);
        refill = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
